// File: rtl/stat_graph_render.sv
// Population history bar graph: samples population counts into a circular history and renders the
// history as bars on the VGA stream. Commits to the history happen only at vsync so frames never tear.
module stat_graph_render #(
  parameter int unsigned POP_WIDTH           = 18,
  parameter int unsigned SCALE_SHIFT         = 11,
  parameter logic [11:0] GRAPH_COLOR         = 12'hF80,
  parameter int unsigned GRAPH_WIDTH         = 128,
  parameter int unsigned GRAPH_HEIGHT        = 128,
  parameter int unsigned GRAPH_SAMPLE_PERIOD = 2,
  parameter int unsigned GRAPH_ORIGIN_X      = 510,
  parameter int unsigned GRAPH_ORIGIN_Y      = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 gen_done_in,
  input  logic [POP_WIDTH-1:0] pop_in,
  input  logic                 clear_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 blank_in,
  output logic [11:0]          pixel_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 blank_out,
  output logic                 overrun_out
);

  localparam int unsigned H_W    = $clog2(GRAPH_HEIGHT);
  localparam int unsigned PTR_W  = $clog2(GRAPH_WIDTH);
  localparam int unsigned SUM_W  = PTR_W + 1;
  localparam int unsigned FILL_W = $clog2(GRAPH_WIDTH + 1);
  localparam int unsigned CNT_W  = (GRAPH_SAMPLE_PERIOD > 1) ? $clog2(GRAPH_SAMPLE_PERIOD) : 1;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [H_W-1:0]      h_pend_q, h_pend_d;
  logic                overrun_d;
  logic                vsync_prev_q;
  logic                ram_we;

  logic [POP_WIDTH-1:0] pop_scaled;
  logic [H_W-1:0]       h_new;
  logic                 sample;
  logic                 vsync_fall;
  logic                 commit;

  assign pop_scaled = pop_in >> SCALE_SHIFT;
  assign h_new      = (pop_scaled > POP_WIDTH'(GRAPH_HEIGHT - 1)) ? H_W'(GRAPH_HEIGHT - 1)
                                                                  : pop_scaled[H_W-1:0];
  assign sample     = gen_done_in && (cnt_q == CNT_W'(GRAPH_SAMPLE_PERIOD - 1));
  assign vsync_fall = vsync_prev_q && !vsync_in;
  assign commit     = (state_q == StPending) && vsync_fall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    h_pend_d  = h_pend_q;
    overrun_d = overrun_out;
    ram_we    = 1'b0;
    if (gen_done_in) begin
      cnt_d = sample ? '0 : cnt_q + CNT_W'(1);
    end
    if (commit) begin
      ram_we   = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(GRAPH_WIDTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fill_q != FILL_W'(GRAPH_WIDTH)) fill_d = fill_q + FILL_W'(1);
      state_d  = StIdle;
    end
    // A sample landing with a commit replaces nothing, so it is not an overrun.
    if (sample) begin
      h_pend_d = h_new;
      state_d  = StPending;
      if ((state_q == StPending) && !vsync_fall) overrun_d = 1'b1;
    end
    if (clear_in) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
      state_d  = StIdle;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      h_pend_q     <= '0;
      overrun_out  <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      h_pend_q     <= h_pend_d;
      overrun_out  <= overrun_d;
      vsync_prev_q <= vsync_in;
    end
  end

  // Render stage 1: box-relative coordinates; wrapped (negative) offsets land outside the box.
  logic [10:0]      x;
  logic [9:0]       y;
  logic             in_box, col_valid;
  logic [SUM_W-1:0] addr_sum;
  logic [PTR_W-1:0] rd_addr;

  assign x         = hcount_in - 11'(GRAPH_ORIGIN_X);
  assign y         = vcount_in - 10'(GRAPH_ORIGIN_Y);
  assign in_box    = (x < 11'(GRAPH_WIDTH)) && (y < 10'(GRAPH_HEIGHT));
  assign col_valid = x >= (11'(GRAPH_WIDTH) - 11'(fill_q));
  assign addr_sum  = SUM_W'(wr_ptr_q) + SUM_W'(x[PTR_W-1:0]);
  assign rd_addr   = (addr_sum >= SUM_W'(GRAPH_WIDTH)) ? PTR_W'(addr_sum - SUM_W'(GRAPH_WIDTH))
                                                       : PTR_W'(addr_sum);

  logic [H_W-1:0] ram [GRAPH_WIDTH];
  logic [H_W-1:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[wr_ptr_q] <= h_pend_q;
    ram_q <= ram[rd_addr];
  end

  logic           in_box_q, col_valid_q;
  logic [H_W-1:0] y_q;
  logic           hsync_q, vsync_q, blank_q;
  logic           lit;

  assign lit = in_box_q && col_valid_q && !blank_q && (y_q >= (H_W'(GRAPH_HEIGHT - 1) - ram_q));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_box_q    <= 1'b0;
      col_valid_q <= 1'b0;
      y_q         <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_q     <= 1'b1;
      pixel_out   <= 12'h000;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_out   <= 1'b1;
    end else begin
      in_box_q    <= in_box;
      col_valid_q <= col_valid;
      y_q         <= y[H_W-1:0];
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      blank_q     <= blank_in;
      pixel_out   <= lit ? GRAPH_COLOR : 12'h000;
      hsync_out   <= hsync_q;
      vsync_out   <= vsync_q;
      blank_out   <= blank_q;
    end
  end

endmodule

// File: tb/tb_stat_graph_render.sv
// Directed bench for stat_graph_render: history commit, wrap, overrun, clear and sync alignment.
module tb_stat_graph_render;

  localparam logic [11:0] COLOR = 12'hF80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gen_done = 1'b0;
  logic [17:0] pop = '0;
  logic        clear = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blank = 1'b0;
  logic [11:0] pixel;
  logic        hsync_o, vsync_o, blank_o, overrun;

  int checks = 0;
  int errors = 0;

  stat_graph_render dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .gen_done_in (gen_done),
    .pop_in      (pop),
    .clear_in    (clear),
    .hcount_in   (hcount),
    .vcount_in   (vcount),
    .hsync_in    (hsync),
    .vsync_in    (vsync),
    .blank_in    (blank),
    .pixel_out   (pixel),
    .hsync_out   (hsync_o),
    .vsync_out   (vsync_o),
    .blank_out   (blank_o),
    .overrun_out (overrun)
  );

  always #5 clk = ~clk;

  task automatic gen(input logic [17:0] v);
    @(negedge clk);
    gen_done = 1'b1;
    pop      = v;
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic vedge();
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Present one coordinate and read the pixel after the two-cycle pipeline.
  task automatic probe(input int h, input int v, output logic [11:0] p);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    @(posedge clk);
    #1 p = pixel;
  endtask

  task automatic test_reset();
    logic [11:0] p;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pixel, hsync_o, vsync_o, blank_o, overrun} !== {12'h000, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got pix=%h hs=%b vs=%b bl=%b ov=%b want 000 1 1 1 0",
               pixel, hsync_o, vsync_o, blank_o, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    probe(510, 10, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL empty_corner: got %h want 000", p); end
    probe(637, 137, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL empty_newest: got %h want 000", p); end
    probe(570, 70, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL empty_mid: got %h want 000", p); end
  endtask

  task automatic test_first_commit();
    logic [11:0] p;
    gen(18'd230399);
    gen(18'd230399);
    vedge();
    probe(637, 25, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL h112_top: got %h want %h", p, COLOR); end
    probe(637, 137, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL h112_base: got %h want %h", p, COLOR); end
    probe(637, 24, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL h112_above: got %h want 000", p); end
    probe(636, 137, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL fill1_x126: got %h want 000", p); end
  endtask

  task automatic test_heights();
    logic [11:0] p;
    gen(18'd0);
    gen(18'd0);
    vedge();
    probe(637, 137, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL h0_base: got %h want %h", p, COLOR); end
    probe(637, 136, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL h0_row126: got %h want 000", p); end
    probe(636, 25, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL shifted_x126: got %h want %h", p, COLOR); end
    // 300000 does not fit 18 bits; the largest count exercises the top of the range.
    gen(18'h3FFFF);
    gen(18'h3FFFF);
    vedge();
    probe(637, 10, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL hmax_top: got %h want %h", p, COLOR); end
    probe(637, 9, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL above_box: got %h want 000", p); end
  endtask

  task automatic test_wrap();
    logic [11:0] p;
    int          hc [6] = '{510, 510, 637, 637, 574, 574};
    int          vc [6] = '{134, 133, 135, 134, 70, 69};
    logic [11:0] ex [6] = '{COLOR, 12'h000, COLOR, 12'h000, COLOR, 12'h000};
    clear_pulse();
    for (int k = 1; k <= 130; k++) begin
      gen(18'((k % 128) << 11));
      gen(18'((k % 128) << 11));
      vedge();
    end
    for (int i = 0; i < 6; i++) begin
      probe(hc[i], vc[i], p);
      checks++;
      if (p !== ex[i]) begin
        errors++;
        $display("FAIL wrap_%0d (h=%0d v=%0d): got %h want %h", i, hc[i], vc[i], p, ex[i]);
      end
    end
  endtask

  task automatic test_overrun_clear();
    logic [11:0] p;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_idle: got %b want 0", overrun); end
    clear_pulse();
    gen(18'(5 << 11));
    gen(18'(5 << 11));
    gen(18'(9 << 11));
    gen(18'(9 << 11));
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    vedge();
    probe(637, 128, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL latest_h9: got %h want %h", p, COLOR); end
    probe(637, 127, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL h9_above: got %h want 000", p); end
    probe(636, 137, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL single_commit: got %h want 000", p); end
    // Clear arriving with a sampling pulse must win and restart the period count.
    gen(18'd230399);
    @(negedge clk);
    gen_done = 1'b1;
    pop      = 18'd230399;
    clear    = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    clear    = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    gen(18'd230399);
    vedge();
    probe(637, 137, p);
    checks++;
    if (p !== 12'h000) begin errors++; $display("FAIL clear_gen_empty: got %h want 000", p); end
    gen(18'd230399);
    vedge();
    probe(637, 137, p);
    checks++;
    if (p !== COLOR) begin errors++; $display("FAIL clear_gen_commit: got %h want %h", p, COLOR); end
  endtask

  task automatic test_sync_align();
    logic [2:0] prev = 3'b111;
    logic [2:0] cur;
    @(negedge clk);
    hcount = 11'd637;
    vcount = 10'd137;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cur = 3'($urandom);
      {hsync, vsync, blank} = cur;
      @(posedge clk);
      #1;
      // Outputs updated at this edge carry the inputs captured one edge earlier.
      if (i > 0) begin
        checks++;
        if ({hsync_o, vsync_o, blank_o} !== prev) begin
          errors++;
          $display("FAIL sync_delay_%0d: got %b want %b", i, {hsync_o, vsync_o, blank_o}, prev);
        end
      end
      if (blank_o === 1'b1) begin
        checks++;
        if (pixel !== 12'h000) begin
          errors++;
          $display("FAIL blank_pixel_%0d: got %h want 000", i, pixel);
        end
      end
      prev = cur;
    end
    @(negedge clk);
    {hsync, vsync, blank} = 3'b110;
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_heights();
    test_wrap();
    test_overrun_clear();
    test_sync_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
